// File: rtl/cordic_iter_pe.sv
// Folded CORDIC processing element: one micro-rotation per clock, vectoring or
// rotation mode, valid/ready handshake on both sides, saturated outputs.
module cordic_iter_pe #(
    parameter int WIDTH = 17,
    parameter int ITER  = 13,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_theta,
    input  logic                    in_mapping,
    input  logic                    in_rot_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_theta,
    output logic                    out_mapping
);

    localparam int FRAC = WIDTH - 3;
    localparam int IW   = WIDTH + GUARD;
    localparam int CW   = 4;
    localparam logic [CW-1:0]        LAST    = CW'(ITER - 1);
    localparam logic signed [IW-1:0] SAT_MAX = IW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITERATE,
        S_SCALE,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [CW-1:0]        r_i;
    logic signed [IW-1:0] r_x, r_y, r_theta;
    logic                 r_mode, r_mapping;
    logic signed [WIDTH-1:0] r_out_x, r_out_y, r_out_theta;
    logic                 r_out_mapping;

    // atan(2^-i) in S2.14, rescaled to the configured fraction width.
    function automatic logic signed [IW-1:0] angle_lut(input logic [CW-1:0] idx);
        int a;
        case (idx)
            4'd0:    a = 12867;
            4'd1:    a = 7596;
            4'd2:    a = 4013;
            4'd3:    a = 2037;
            4'd4:    a = 1022;
            4'd5:    a = 511;
            4'd6:    a = 255;
            4'd7:    a = 127;
            4'd8:    a = 63;
            4'd9:    a = 31;
            4'd10:   a = 15;
            4'd11:   a = 7;
            4'd12:   a = 3;
            4'd13:   a = 1;
            4'd14:   a = 1;
            default: a = 0;
        endcase
        return IW'(a >>> (14 - FRAC));
    endfunction

    function automatic logic signed [IW-1:0] scale(input logic signed [IW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 12) + (v >>> 14);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] c;
        c = v;
        if (v > SAT_MAX) c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        return c[WIDTH-1:0];
    endfunction

    logic signed [IW-1:0] w_x_ext, w_y_ext, w_t_ext;
    logic signed [IW-1:0] w_x0, w_y0, w_t0;
    logic                 w_map0;
    logic                 w_accept;

    assign w_x_ext  = {{GUARD{in_x[WIDTH-1]}}, in_x};
    assign w_y_ext  = {{GUARD{in_y[WIDTH-1]}}, in_y};
    assign w_t_ext  = {{GUARD{in_theta[WIDTH-1]}}, in_theta};
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // Half-plane pre-map so the micro-rotations only need to cover +-99 degrees.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that skips
        // an assignment would otherwise infer a latch.
        w_x0   = w_x_ext;
        w_y0   = w_y_ext;
        w_t0   = '0;
        w_map0 = 1'b0;
        if (in_mode) begin
            if (in_x[WIDTH-1]) begin
                w_x0   = -w_x_ext;
                w_map0 = 1'b1;
            end
        end else begin
            w_map0 = in_mapping;
            if (!in_rot_zero) begin
                w_t0 = w_t_ext;
                if (in_mapping) begin
                    w_x0 = -w_x_ext;
                    w_y0 = -w_y_ext;
                end
            end
        end
    end

    logic                 w_d;
    logic signed [IW-1:0] w_xs, w_ys, w_a;
    logic signed [IW-1:0] w_x_nx, w_y_nx, w_t_nx, w_theta_fin;

    assign w_d    = r_mode ? !r_y[IW-1] : r_theta[IW-1];
    assign w_xs   = r_x >>> r_i;
    assign w_ys   = r_y >>> r_i;
    assign w_a    = angle_lut(r_i);
    assign w_x_nx = w_d ? r_x + w_ys : r_x - w_ys;
    assign w_y_nx = w_d ? r_y - w_xs : r_y + w_xs;
    assign w_t_nx = w_d ? r_theta + w_a : r_theta - w_a;
    assign w_theta_fin = (r_mode && !r_mapping) ? -r_theta : r_theta;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_ITERATE;
            S_ITERATE: if (r_i == LAST) w_next = S_SCALE;
            S_SCALE:   w_next = S_DONE;
            S_DONE:    if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees pre-edge values, which the x/y cross-update depends on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_theta       <= '0;
            r_mode        <= 1'b0;
            r_mapping     <= 1'b0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_out_theta   <= '0;
            r_out_mapping <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_i       <= '0;
                        r_x       <= w_x0;
                        r_y       <= w_y0;
                        r_theta   <= w_t0;
                        r_mode    <= in_mode;
                        r_mapping <= w_map0;
                    end
                end
                S_ITERATE: begin
                    r_x     <= w_x_nx;
                    r_y     <= w_y_nx;
                    r_theta <= w_t_nx;
                    r_i     <= r_i + CW'(1);
                end
                S_SCALE: begin
                    r_out_x       <= sat(scale(r_x));
                    r_out_y       <= sat(scale(r_y));
                    r_out_theta   <= sat(w_theta_fin);
                    r_out_mapping <= r_mapping;
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = (r_state == S_DONE);
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign out_theta   = r_out_theta;
    assign out_mapping = r_out_mapping;

endmodule

// File: doc/cordic_iter_pe.md
# cordic_iter_pe

Parametrised, folded CORDIC processing element for the QR-decomposition array. It runs vectoring mode (computes magnitude and angle) and rotation mode (applies a stored angle). It performs one micro-rotation per clock instead of an unrolled chain, and adds a valid/ready handshake, configurable width and iteration count, internal guard bits and output saturation. It is the drop-in building block for larger or time-multiplexed systolic QRD arrays.

## Interface
- WIDTH, 17: data width, signed fixed point S2.(WIDTH-3); legal range 12..17.
- ITER, 13: micro-rotation count; legal range 4..16.
- GUARD, 2: extra MSBs on internal x/y/theta datapath.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input request.
- in_ready  out  1  block can accept; high only in IDLE.
- in_mode  in  1  1 = vectoring, 0 = rotation.
- in_x, in_y, in_theta  in  WIDTH each  operands; in_theta is used in rotation mode only.
- in_mapping  in  1  rotation mode: stored half-plane flag from the earlier vectoring pass.
- in_rot_zero  in  1  rotation mode: force a zero-angle rotation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_x, out_y, out_theta  out  WIDTH each  results.
- out_mapping  out  1  vectoring mode: computed flag; rotation mode: in_mapping passed through.

## Operation
- States: IDLE, ITERATE, SCALE, DONE.
- IDLE -> ITERATE on in_valid & in_ready. That edge captures the mapped operands, sign-extended by GUARD, and clears the counter i.
- Vectoring pre-map:
  - x<0: x = -x, mapping = 1.
  - Otherwise x is unchanged, mapping = 0.
  - y is unchanged; theta = 0.
- Rotation pre-map:
  - in_rot_zero = 1: x and y unchanged, theta = 0.
  - Else in_mapping = 1: x = -x, y = -y, theta unchanged.
  - Else all unchanged.
  - mapping = in_mapping in every case.
- ITERATE: one micro-rotation per cycle.
  - Direction d = (y >= 0) in vectoring, d = (theta < 0) in rotation.
  - d = 1: x += y>>>i, y -= x>>>i, theta += a_i.
  - d = 0: x -= y>>>i, y += x>>>i, theta -= a_i.
  - Both updates use the pre-update x and y.
- ITERATE -> SCALE when i = ITER-1.
- Angle table a_i for FRAC=14: 12867, 7596, 4013, 2037, 1022, 511, 255, 127, 63, 31, 15, 7, 3, 1, 1, 0. For FRAC<14, use the same value arithmetically shifted right by 14-FRAC.
- SCALE, one cycle:
  - x' = (x>>>1)+(x>>>3)-(x>>>6)-(x>>>9)-(x>>>12)+(x>>>14); same for y. This is gain 0.6072.
  - Vectoring out_theta = mapping ? theta : -theta. Rotation out_theta = theta.
  - Saturate x', y' and out_theta to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register all outputs and go to DONE.
- DONE: hold every output stable while out_valid=1. On out_ready=1 go to IDLE.
- Internal arithmetic is two's complement at WIDTH+GUARD bits and wraps. Only the final outputs saturate.

## Timing
- Reset: state IDLE; all registers and outputs 0. out_valid=0, out_mapping=0, in_ready=0 while rst is high. in_ready=1 on the first cycle after rst falls.
- Latency: out_valid rises ITER+1 cycles after the accept edge (14 at default).
- Throughput: one operation per ITER+3 cycles with out_ready held high. in_ready rises the cycle after the output handshake. There is no overlap of accept with DONE.
- in_valid while busy is ignored and not queued. Operands are sampled only on the accept edge; input changes afterwards have no effect.
- rst during ITERATE, SCALE or DONE aborts the operation. Next cycle: out_valid=0, the state is IDLE, and no stale result is ever presented.
- out_ready while out_valid=0 has no effect.

## Test plan
- Vectoring (16384, 16384) -> out_x 23170±8, out_y 0±8, out_theta -12868±8, out_mapping 0, out_valid exactly 14 cycles after accept.
- Vectoring (-16384, 0) -> out_mapping 1, out_x 16384±8, out_y 0±8, out_theta 0±16.
- Rotation x=16384, y=0, theta=-12868, mapping 0 -> out_x 11585±8, out_y -11585±8. Repeat with in_rot_zero=1, theta=9999, x=5000, y=-3000 -> out (5000, -3000)±8.
- Saturation: vectoring (65535, 65535) -> out_x 65535, no wrap to negative; out_theta -12868±8.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and all outputs constant, in_ready 0. Then out_ready=1 -> out_valid 0 and in_ready 1 on the next cycle. Back-to-back requests are accepted every 16 cycles.
- Reset at iteration 5 -> next cycle out_valid 0, outputs 0. After release, a fresh vectoring (16384, 16384) gives the correct result.
